uart_rx: RTL and testbench

- 8N1 UART receiver for the bot's serial command link.
- Consumes the serial line after it has passed through the two-stage d_ff synchroniser chain; this block does not synchronise its input.
- Produces one byte per frame with a single-cycle valid strobe.
- Flags framing errors to the command decoder downstream.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of an already-synchronised serial line,
// one-cycle valid / framing-error strobes, registered outputs.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_sync,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CW       = $clog2(CLKS_PER_BIT) + 1;

    // Terminal counts are one less than the offsets: the entry cycle of a state holds count 0.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;
    logic          ferr_q,  ferr_d;
    logic          busy_q,  busy_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy_q tracks state_q != IDLE with no extra delay by registering the next state.
    assign busy_d    = (state_d != IDLE);

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 8 clocks/bit, one at the default rate.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx8, rx434;
    logic [7:0] d8, d4;
    logic       v8, e8, b8, v4, e4, b4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int         v8_cnt = 0, v8_cyc = 0, v8_prev_cyc = 0, e8_cnt = 0, e8_cyc = 0;
    logic [7:0] v8_data = 8'h00, v8_prev_data = 8'h00;
    int         v4_cnt = 0, v4_cyc = 0, e4_cnt = 0;
    logic [7:0] v4_data = 8'h00;
    logic       both_seen = 1'b0;
    logic       busy_first, busy_stop, busy_after;
    int         s, s2;

    uart_rx #(.CLKS_PER_BIT(8)) dut8 (
        .clock(clk), .reset(rst), .rx_sync(rx8),
        .rx_data(d8), .rx_valid(v8), .frame_err(e8), .busy(b8)
    );

    uart_rx dut434 (
        .clock(clk), .reset(rst), .rx_sync(rx434),
        .rx_data(d4), .rx_valid(v4), .frame_err(e4), .busy(b4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (v8 === 1'b1) begin
            v8_prev_cyc  = v8_cyc;
            v8_prev_data = v8_data;
            v8_cyc       = cyc;
            v8_data      = d8;
            v8_cnt++;
        end
        if (e8 === 1'b1) begin
            e8_cnt++;
            e8_cyc = cyc;
        end
        if (v4 === 1'b1) begin
            v4_cnt++;
            v4_cyc  = cyc;
            v4_data = d4;
        end
        if (e4 === 1'b1) e4_cnt++;
        if ((v8 === 1'b1 && e8 === 1'b1) || (v4 === 1'b1 && e4 === 1'b1)) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a clock edge; the following edge is frame cycle 0.
    task automatic send(input bit big, input logic [7:0] b, input bit stop_bit,
                        input int abort_j, output int start_cyc);
        int c = big ? 434 : 8;
        int h = c / 2;
        int j = 0;
        logic [9:0] frame;
        frame     = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (big) rx434 = frame[i];
            else     rx8   = frame[i];
            for (int k = 0; k < c; k++) begin
                @(posedge clk);
                #1;
                j++;
                if (j == 1)             busy_first = big ? b4 : b8;
                if (j == h + 9 * c)     busy_stop  = big ? b4 : b8;
                if (j == h + 9 * c + 2) busy_after = big ? b4 : b8;
                if (abort_j != 0 && j == abort_j) rst = 1'b1;
                if (abort_j != 0 && j == abort_j + 1) begin
                    rst = 1'b0;
                    rx8 = 1'b1;
                    return;
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        rx8   = 1'b1;
        rx434 = 1'b1;
        idle(3);
        check("rst_data8",  d8, 8'h00);
        check("rst_valid8", v8, 1'b0);
        check("rst_ferr8",  e8, 1'b0);
        check("rst_busy8",  b8, 1'b0);
        check("rst_data434", d4, 8'h00);
        check("rst_busy434", b4, 1'b0);
        rst = 1'b0;
        idle(2);

        // Single frame 0xA5
        send(1'b0, 8'hA5, 1'b1, 0, s);
        check("t1_vcnt",  v8_cnt, 1);
        check("t1_lat",   v8_cyc - s, 77);
        check("t1_data",  v8_data, 8'hA5);
        check("t1_ferr",  e8_cnt, 0);
        check("t1_busy1", busy_first, 1'b1);
        check("t1_busyS", busy_stop, 1'b1);
        check("t1_busy78", busy_after, 1'b0);

        // Glitch: two low cycles
        rx8 = 1'b0;
        idle(2);
        check("t2_busy_in", b8, 1'b1);
        rx8 = 1'b1;
        idle(10);
        check("t2_busy", b8, 1'b0);
        check("t2_vcnt", v8_cnt, 1);
        check("t2_ferr", e8_cnt, 0);
        check("t2_data", d8, 8'hA5);

        // Framing error with held-low line
        send(1'b0, 8'h3C, 1'b0, 0, s);
        check("t3_ecnt", e8_cnt, 1);
        check("t3_elat", e8_cyc - s, 77);
        check("t3_vcnt", v8_cnt, 1);
        check("t3_data", d8, 8'hA5);
        idle(40);
        check("t3_busy_low", b8, 1'b1);
        check("t3_ecnt2", e8_cnt, 1);
        check("t3_vcnt2", v8_cnt, 1);
        rx8 = 1'b1;
        idle(4);
        check("t3_idle", b8, 1'b0);
        send(1'b0, 8'h5A, 1'b1, 0, s);
        check("t3_vcnt3", v8_cnt, 2);
        check("t3_lat",   v8_cyc - s, 77);
        check("t3_data2", d8, 8'h5A);
        check("t3_ecnt3", e8_cnt, 1);

        // Back-to-back frames
        send(1'b0, 8'h00, 1'b1, 0, s);
        send(1'b0, 8'hFF, 1'b1, 0, s2);
        check("t4_vcnt",  v8_cnt, 4);
        check("t4_gap",   v8_cyc - v8_prev_cyc, 80);
        check("t4_data0", v8_prev_data, 8'h00);
        check("t4_data1", v8_data, 8'hFF);
        check("t4_lat",   v8_cyc - s2, 77);

        // Reset during data bit 3
        idle(4);
        send(1'b0, 8'hC3, 1'b1, 34, s);
        check("t5_data",  d8, 8'h00);
        check("t5_valid", v8, 1'b0);
        check("t5_ferr",  e8, 1'b0);
        check("t5_busy",  b8, 1'b0);
        idle(20);
        check("t5_vcnt",  v8_cnt, 4);
        check("t5_ecnt",  e8_cnt, 1);
        send(1'b0, 8'h81, 1'b1, 0, s);
        check("t5_vcnt2", v8_cnt, 5);
        check("t5_data2", d8, 8'h81);
        check("t5_lat",   v8_cyc - s, 77);

        // Default rate
        send(1'b1, 8'h4B, 1'b1, 0, s);
        check("t6_vcnt", v4_cnt, 1);
        check("t6_lat",  v4_cyc - s, 4124);
        check("t6_data", v4_data, 8'h4B);
        check("t6_ecnt", e4_cnt, 0);

        check("excl", both_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
